// File: rtl/ps2_key_event_fifo_pkg.sv
// Key codes and event encoding shared by the PS/2 key event path.
// A release event is the released code with KEY_RELEASE_FLAG set.
package ps2_key_pkg;

  localparam int KEY_W = 16;

  typedef logic [KEY_W-1:0] key_code_t;

  localparam key_code_t KEY_NONE         = 16'h0000;
  localparam key_code_t KEY_LEFT         = 16'h0001;
  localparam key_code_t KEY_RIGHT        = 16'h0002;
  localparam key_code_t KEY_UP           = 16'h0003;
  localparam key_code_t KEY_DOWN         = 16'h0004;
  localparam key_code_t KEY_SHOOT        = 16'h0005;
  localparam key_code_t KEY_RELEASE_FLAG = 16'h8000;

  // Key-to-key changes report only the new key; the old key gets no release.
  function automatic key_code_t key_event(input key_code_t old_code, input key_code_t new_code);
    return (new_code == KEY_NONE) ? (KEY_RELEASE_FLAG | old_code) : new_code;
  endfunction

endpackage

// File: rtl/ps2_key_event_fifo_if.sv
// CPU-side read port of the key event queue: pop/clear strobes in, queue status out.
// master = CPU/MMIO logic, slave = event queue.
interface ps2_key_event_fifo_if #(
  parameter int DEPTH = 8
) ();
  import ps2_key_pkg::*;

  logic                         rd_en;
  logic                         clr_ovf;
  key_code_t                    rd_data;
  logic                         empty;
  logic                         full;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         overflow;
  key_code_t                    key_state;

  modport master (
    output rd_en, clr_ovf,
    input  rd_data, empty, full, count, overflow, key_state
  );

  modport slave (
    input  rd_en, clr_ovf,
    output rd_data, empty, full, count, overflow, key_state
  );

endinterface

// File: rtl/ps2_key_event_fifo_key_fifo.sv
// Generic first-word-fall-through FIFO; rd_dat valid combinationally, reads 0 when empty.
// Push is never stalled: a push into a full FIFO without a pop is dropped and sets sticky overflow.
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  input  logic                       clr_ovf,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop, drop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign overflow = ovf_q;
  assign rd_dat   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && !empty;
    // When full, a same-edge pop frees the head slot, which is exactly wr_ptr.
    do_push  = push && (!full || do_pop);
    drop     = push && !do_push;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    ovf_d   = drop | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: rtl/ps2_key_event_fifo.sv
// Syncs and debounces the PS/2 key code, turns committed changes into press/release events, queues them.
// Event queued SYNC_STAGES+STABLE_CYCLES edges after an input change; no backpressure, drops flag overflow.
module ps2_key_event_fifo
  import ps2_key_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  key_code_t            keyboard_input,
  ps2_key_event_fifo_if.slave  cpu
);

  localparam int               STB_W   = $clog2(STABLE_CYCLES+1);
  localparam logic [STB_W-1:0] STB_MAX = STB_W'(STABLE_CYCLES-1);

  key_code_t        sync_q [SYNC_STAGES];
  key_code_t        sync_d [SYNC_STAGES];
  key_code_t        sync_out;
  key_code_t        cand_q, cand_d;
  key_code_t        key_state_q, key_state_d;
  logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
  logic             evt_vld;
  key_code_t        evt_dat;

  always_comb begin
    sync_d[0] = keyboard_input;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Bits of a multi-bit code may land on different edges; only a code that
  // holds for the whole window is trusted.
  always_comb begin
    cand_d      = cand_q;
    stb_cnt_d   = stb_cnt_q;
    key_state_d = key_state_q;
    evt_vld     = 1'b0;
    evt_dat     = '0;
    if (sync_out != cand_q) begin
      cand_d    = sync_out;
      stb_cnt_d = '0;
    end else begin
      if (stb_cnt_q != STB_MAX) begin
        stb_cnt_d = stb_cnt_q + 1'b1;
      end
      if (stb_cnt_q == STB_MAX && cand_q != key_state_q) begin
        key_state_d = cand_q;
        evt_vld     = 1'b1;
        evt_dat     = key_event(key_state_q, cand_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      cand_q      <= '0;
      stb_cnt_q   <= '0;
      key_state_q <= '0;
    end else begin
      sync_q      <= sync_d;
      cand_q      <= cand_d;
      stb_cnt_q   <= stb_cnt_d;
      key_state_q <= key_state_d;
    end
  end

  key_fifo #(
    .DEPTH (DEPTH),
    .W     (KEY_W)
  ) u_key_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (evt_vld),
    .push_dat (evt_dat),
    .pop      (cpu.rd_en),
    .clr_ovf  (cpu.clr_ovf),
    .rd_dat   (cpu.rd_data),
    .count    (cpu.count),
    .full     (cpu.full),
    .empty    (cpu.empty),
    .overflow (cpu.overflow)
  );

  assign cpu.key_state = key_state_q;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Directed bench for ps2_key_event_fifo at default parameters; inputs change on negedge, outputs sampled on negedge.
module tb_ps2_key_event_fifo;
  import ps2_key_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  key_code_t kb;
  int        tests_run    = 0;
  int        tests_failed = 0;

  logic [15:0] exp_q [8];

  ps2_key_event_fifo_if #(.DEPTH(8)) cpu ();

  ps2_key_event_fifo #(
    .DEPTH         (8),
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .keyboard_input (kb),
    .cpu            (cpu.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input key_code_t v);
    kb = v;
    tick(8);
  endtask

  task automatic pop();
    cpu.rd_en = 1'b1;
    tick(1);
    cpu.rd_en = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_data"},   cpu.rd_data,   32'h0);
    check({tag, "_empty"},     cpu.empty,     32'h1);
    check({tag, "_full"},      cpu.full,      32'h0);
    check({tag, "_count"},     cpu.count,     32'h0);
    check({tag, "_overflow"},  cpu.overflow,  32'h0);
    check({tag, "_key_state"}, cpu.key_state, 32'h0);
  endtask

  task automatic drain_check(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_rd%0d", tag, i), cpu.rd_data, exp_q[i]);
      pop();
    end
    check({tag, "_empty_after"}, cpu.empty, 32'h1);
  endtask

  initial begin
    reset       = 1'b1;
    kb          = '0;
    cpu.rd_en   = 1'b0;
    cpu.clr_ovf = 1'b0;
    #2 reset = 1'b0;
    #2 check_reset_vals("rst");
    tick(2);
    reset = 1'b1;
    tick(2);

    // Press: visible after e6, not after e5
    kb = 16'h0001;
    tick(6);
    check("t1_empty_e5", cpu.empty, 32'h1);
    check("t1_key_e5",   cpu.key_state, 32'h0);
    tick(1);
    check("t1_empty_e6", cpu.empty, 32'h0);
    check("t1_rd_data",  cpu.rd_data, 32'h0001);
    check("t1_key",      cpu.key_state, 32'h0001);
    check("t1_count",    cpu.count, 32'h1);
    pop();
    check("t1_empty_pop", cpu.empty, 32'h1);
    check("t1_rd_zero",   cpu.rd_data, 32'h0);
    set_key(16'h0000);
    check("t1_release", cpu.rd_data, 32'h8001);
    pop();

    // Press then release queued in order
    set_key(16'h0001);
    set_key(16'h0000);
    check("t2_count", cpu.count, 32'h2);
    check("t2_first", cpu.rd_data, 32'h0001);
    pop();
    check("t2_second", cpu.rd_data, 32'h8001);
    pop();
    check("t2_empty", cpu.empty, 32'h1);

    // Short glitch never commits
    kb = 16'h0003;
    tick(3);
    kb = 16'h0000;
    tick(10);
    check("t3_count", cpu.count, 32'h0);
    check("t3_key",   cpu.key_state, 32'h0);
    check("t3_empty", cpu.empty, 32'h1);

    // Nine events, no reads: ninth dropped
    for (int i = 1; i <= 4; i++) begin
      set_key(key_code_t'(i));
      set_key(16'h0000);
    end
    set_key(16'h0005);
    check("t4_full",     cpu.full, 32'h1);
    check("t4_count",    cpu.count, 32'h8);
    check("t4_overflow", cpu.overflow, 32'h1);
    check("t4_key",      cpu.key_state, 32'h0005);
    exp_q = '{16'h0001, 16'h8001, 16'h0002, 16'h8002, 16'h0003, 16'h8003, 16'h0004, 16'h8004};
    drain_check("t4");
    check("t4_ovf_sticky", cpu.overflow, 32'h1);
    cpu.clr_ovf = 1'b1;
    tick(1);
    cpu.clr_ovf = 1'b0;
    check("t4_ovf_clr", cpu.overflow, 32'h0);

    // Full queue, commit coincides with a pop
    set_key(16'h0000);
    set_key(16'h0001);
    set_key(16'h0000);
    set_key(16'h0002);
    set_key(16'h0000);
    set_key(16'h0003);
    set_key(16'h0000);
    set_key(16'h0004);
    check("t5_full_pre", cpu.full, 32'h1);
    kb = 16'h0000;
    tick(6);
    check("t5_head_pre",  cpu.rd_data, 32'h8005);
    check("t5_count_pre", cpu.count, 32'h8);
    cpu.rd_en = 1'b1;
    tick(1);
    cpu.rd_en = 1'b0;
    check("t5_count",    cpu.count, 32'h8);
    check("t5_overflow", cpu.overflow, 32'h0);
    check("t5_full",     cpu.full, 32'h1);
    check("t5_key",      cpu.key_state, 32'h0);
    exp_q = '{16'h0001, 16'h8001, 16'h0002, 16'h8002, 16'h0003, 16'h8003, 16'h0004, 16'h8004};
    drain_check("t5");

    // Reset mid-operation with key held
    set_key(16'h0005);
    set_key(16'h0000);
    set_key(16'h0005);
    check("t6_count_pre", cpu.count, 32'h3);
    reset = 1'b0;
    #1 check_reset_vals("t6");
    tick(2);
    reset = 1'b1;
    tick(6);
    check("t6_empty_e5", cpu.empty, 32'h1);
    tick(1);
    check("t6_rd_data", cpu.rd_data, 32'h0005);
    check("t6_count",   cpu.count, 32'h1);
    check("t6_key",     cpu.key_state, 32'h0005);
    tick(4);
    check("t6_count_hold", cpu.count, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
